// File: rtl/parking_pkg.sv
// parking_pkg: shared gate state encoding and helpers for parking blocks
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    HOLD = 2'd2
  } gate_state_t;

  // One counter serves both the hold countdown and the open timeout, so size it for the larger.
  function automatic int cnt_width(input int hold_cycles, input int timeout_cycles);
    int m;
    m = (hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gate_fsm.sv
// gate_fsm: one barrier sequencer (IDLE/OPEN/HOLD) with shared hold/timeout counter
module gate_fsm
  import parking_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  input  logic qual,
  input  logic passed,
  output logic gate_open,
  output logic accepted,
  output logic timeout
);

  localparam int CW = cnt_width(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  gate_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic open_nxt, timeout_nxt, to_hit;

  // State, counter and the registered gate/timeout outputs
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gate_open <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gate_open <= open_nxt;
      timeout   <= timeout_nxt;
    end

  // Next state: OPEN counts up toward the timeout, HOLD counts down to close
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (sensor && qual) begin
        state_nxt = OPEN;
        cnt_nxt   = '0;
      end
      OPEN: if (passed) begin
        state_nxt = HOLD;
        cnt_nxt   = HOLD_LD;
      end else if (to_hit) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
      HOLD: if (cnt <= CW'(1)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CW'(1);
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: a passed pulse only counts while waiting in OPEN; it also beats a same-edge timeout
  always_comb begin
    to_hit      = cnt == TO_LAST;
    accepted    = (state == OPEN) && passed;
    open_nxt    = state_nxt != IDLE;
    timeout_nxt = (state == OPEN) && !passed && to_hit;
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit barrier controller with occupancy tracking
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY       = 8,
  parameter int OCC_W          = 8,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  input  logic             entry_passed,
  input  logic             exit_passed,
  output logic             entry_gate_open,
  output logic             exit_gate_open,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             entry_timeout,
  output logic             exit_timeout,
  output logic             count_error
);

  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  logic entry_acc, exit_acc, occ_up, occ_dn, err_nxt;
  logic [OCC_W-1:0] occ_nxt;

  gate_fsm #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_entry (
    .clk      (clk),
    .reset    (reset),
    .sensor   (entry_sensor),
    .qual     (~full),
    .passed   (entry_passed),
    .gate_open(entry_gate_open),
    .accepted (entry_acc),
    .timeout  (entry_timeout)
  );

  gate_fsm #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_exit (
    .clk      (clk),
    .reset    (reset),
    .sensor   (exit_sensor),
    .qual     (1'b1),
    .passed   (exit_passed),
    .gate_open(exit_gate_open),
    .accepted (exit_acc),
    .timeout  (exit_timeout)
  );

  assign full  = occupancy == CAP;
  assign empty = occupancy == '0;

  // Net occupancy change; simultaneous entry and exit cancel, over/underflow is rejected
  always_comb begin
    occ_up  = entry_acc & ~exit_acc;
    occ_dn  = exit_acc & ~entry_acc;
    err_nxt = (occ_up & full) | (occ_dn & empty);
    occ_nxt = err_nxt ? occupancy :
              occ_up  ? occupancy + OCC_W'(1) :
              occ_dn  ? occupancy - OCC_W'(1) : occupancy;
  end

  // Occupancy register and error pulse
  always_ff @(posedge clk)
    if (reset) begin
      occupancy   <= '0;
      count_error <= 1'b0;
    end else begin
      occupancy   <= occ_nxt;
      count_error <= err_nxt;
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed scenarios plus random traffic against a deadline-based model
module tb_parking_gate_ctrl;

  localparam int CAP = 3;
  localparam int HC  = 4;
  localparam int TC  = 20;

  logic clk = 1'b0;
  logic reset, entry_sensor, exit_sensor, entry_passed, exit_passed;
  logic entry_gate_open, exit_gate_open, full, empty, entry_timeout, exit_timeout, count_error;
  logic [7:0] occupancy;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int m_occ = 0;
  bit m_err = 0;
  bit e_busy = 0, e_wait = 0, e_to = 0;
  bit x_busy = 0, x_wait = 0, x_to = 0;
  int e_dl = 0, x_dl = 0;
  int err_seen, to_seen;

  parking_gate_ctrl #(
    .CAPACITY      (CAP),
    .OCC_W         (8),
    .HOLD_CYCLES   (HC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .entry_sensor   (entry_sensor),
    .exit_sensor    (exit_sensor),
    .entry_passed   (entry_passed),
    .exit_passed    (exit_passed),
    .entry_gate_open(entry_gate_open),
    .exit_gate_open (exit_gate_open),
    .occupancy      (occupancy),
    .full           (full),
    .empty          (empty),
    .entry_timeout  (entry_timeout),
    .exit_timeout   (exit_timeout),
    .count_error    (count_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // A gate is busy from the sensor edge until an absolute closing deadline:
  // while waiting the deadline is the timeout, after a pass it is the end of the hold.
  task automatic gate_model(inout bit busy, inout bit waiting, inout int dl, output bit to,
                            input bit s, input bit q, input bit p);
    to = 0;
    if (!busy) begin
      if (s && q) begin
        busy = 1; waiting = 1; dl = cyc + TC;
      end
    end else if (waiting) begin
      if (p) begin
        waiting = 0; dl = cyc + HC;
      end else if (cyc == dl) begin
        busy = 0; waiting = 0; to = 1;
      end
    end else if (cyc == dl) begin
      busy = 0;
    end
  endtask

  task automatic model_edge(input bit es, input bit xs, input bit ep, input bit xp, input bit r);
    bit acc_e, acc_x;
    int net;
    cyc++;
    if (r) begin
      m_occ = 0; m_err = 0;
      e_busy = 0; e_wait = 0; e_to = 0;
      x_busy = 0; x_wait = 0; x_to = 0;
    end else begin
      acc_e = e_busy && e_wait && ep;
      acc_x = x_busy && x_wait && xp;
      gate_model(e_busy, e_wait, e_dl, e_to, es, m_occ != CAP, ep);
      gate_model(x_busy, x_wait, x_dl, x_to, xs, 1'b1, xp);
      net = int'(acc_e) - int'(acc_x);
      m_err = (net == 1 && m_occ == CAP) || (net == -1 && m_occ == 0);
      if (!m_err) m_occ += net;
    end
  endtask

  task automatic step(input bit es, input bit xs, input bit ep, input bit xp, input bit r);
    reset = r; entry_sensor = es; exit_sensor = xs; entry_passed = ep; exit_passed = xp;
    @(posedge clk);
    model_edge(es, xs, ep, xp, r);
    #1;
    check("entry_gate_open", int'(entry_gate_open), int'(e_busy));
    check("exit_gate_open", int'(exit_gate_open), int'(x_busy));
    check("occupancy", int'(occupancy), m_occ);
    check("full", int'(full), int'(m_occ == CAP));
    check("empty", int'(empty), int'(m_occ == 0));
    check("entry_timeout", int'(entry_timeout), int'(e_to));
    check("exit_timeout", int'(exit_timeout), int'(x_to));
    check("count_error", int'(count_error), int'(m_err));
    err_seen += int'(count_error);
    to_seen += int'(entry_timeout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_entry();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(6);
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    check("reset_empty", int'(empty), 1);
    check("reset_occ", int'(occupancy), 0);
    // Long sensor presence, then pass: open until HC cycles after pulse
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < HC - 1; i++) step(0, 0, 0, 0, 0);
    check("hold_last_open", int'(entry_gate_open), 1);
    step(0, 0, 0, 0, 0);
    check("hold_closed", int'(entry_gate_open), 0);
    check("first_entry_occ", int'(occupancy), 1);
    // Fill the lot; a further arrival must not open the gate
    do_entry();
    do_entry();
    check("filled_occ", int'(occupancy), 3);
    check("filled_full", int'(full), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    check("full_gate_shut", int'(entry_gate_open), 0);
    // Timeout with no pass
    step(0, 0, 0, 0, 1);
    to_seen = 0;
    step(1, 0, 0, 0, 0);
    idle(TC + 3);
    check("timeout_pulses", to_seen, 1);
    check("timeout_occ", int'(occupancy), 0);
    // Simultaneous accepted entry and exit
    do_entry();
    err_seen = 0;
    step(1, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    idle(6);
    check("simul_occ", int'(occupancy), 1);
    check("simul_err", err_seen, 0);
    // Exit from an empty lot
    step(0, 0, 0, 0, 1);
    err_seen = 0;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(6);
    check("underflow_err", err_seen, 1);
    check("underflow_occ", int'(occupancy), 0);
    check("underflow_empty", int'(empty), 1);
    // Reset during hold
    do_entry();
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("pre_reset_occ", int'(occupancy), 2);
    step(0, 0, 0, 0, 1);
    check("post_reset_gate", int'(entry_gate_open), 0);
    check("post_reset_occ", int'(occupancy), 0);
    check("post_reset_empty", int'(empty), 1);
    // Random traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 499) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
